// File: rtl/qpu_exu_rf_wbarb.sv
// Writeback arbiter: round-robin between ALU and long-pipe requesters into a
// single output stage that drives the classical and quantum-mask write ports.

package qpu_defines_pkg;
  localparam int unsigned QPU_XLEN             = 32;
  localparam int unsigned QPU_RFIDX_WIDTH      = 5;
  localparam int unsigned QPU_RFIDX_REAL_WIDTH = QPU_RFIDX_WIDTH + 1;
  localparam int unsigned QPU_QUBIT_NUM        = 8;
endpackage

module qpu_exu_rf_wbarb
  import qpu_defines_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,

  input  logic                            alu_wbck_i_valid,
  output logic                            alu_wbck_i_ready,
  input  logic [QPU_RFIDX_REAL_WIDTH-1:0] alu_wbck_i_idx,
  input  logic [QPU_XLEN-1:0]             alu_wbck_i_data,

  input  logic                            longp_wbck_i_valid,
  output logic                            longp_wbck_i_ready,
  input  logic [QPU_RFIDX_REAL_WIDTH-1:0] longp_wbck_i_idx,
  input  logic [QPU_XLEN-1:0]             longp_wbck_i_data,

  input  logic                            rf_wbck_hold,

  output logic                            cwbck_dest_wen,
  output logic [QPU_RFIDX_REAL_WIDTH-1:0] cwbck_dest_idx,
  output logic [QPU_XLEN-1:0]             cwbck_dest_data,

  output logic                            qcwbck_dest_wen,
  output logic [QPU_RFIDX_REAL_WIDTH-1:0] qcwbck_dest_idx,
  output logic [QPU_XLEN-1:0]             qcwbck_dest_data,

  output logic                            wbck_drop,
  output logic                            wbck_busy
);

  localparam logic [QPU_RFIDX_WIDTH-1:0] QUBIT_LIM = QPU_RFIDX_WIDTH'(QPU_QUBIT_NUM);

  typedef enum logic {
    PRI_ALU   = 1'b0,
    PRI_LONGP = 1'b1
  } rr_e;

  rr_e rr, rr_nxt;

  logic                            stage_vld;
  logic [QPU_RFIDX_REAL_WIDTH-1:0] stage_idx;
  logic [QPU_XLEN-1:0]             stage_data;

  logic stage_acc;
  logic grant_alu, grant_longp;
  logic alu_xfer, longp_xfer, xfer;
  logic drain, is_quantum, is_ro;
  logic [QPU_RFIDX_WIDTH-1:0] low_field;

  assign stage_acc = ~stage_vld | ~rf_wbck_hold;

  // Round-robin pointer: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr <= PRI_ALU;
    else        rr <= rr_nxt;
  end

  // Round-robin pointer: next state moves only on a completed transfer
  always_comb begin
    rr_nxt = rr;
    if (alu_xfer)        rr_nxt = PRI_LONGP;
    else if (longp_xfer) rr_nxt = PRI_ALU;
  end

  // Round-robin pointer: grant decode
  always_comb begin
    grant_alu   = 1'b0;
    grant_longp = 1'b0;
    if (alu_wbck_i_valid && longp_wbck_i_valid) begin
      grant_alu   = (rr == PRI_ALU);
      grant_longp = (rr == PRI_LONGP);
    end else begin
      grant_alu   = alu_wbck_i_valid;
      grant_longp = longp_wbck_i_valid;
    end
  end

  assign alu_wbck_i_ready   = grant_alu & stage_acc;
  assign longp_wbck_i_ready = grant_longp & stage_acc;
  assign alu_xfer           = alu_wbck_i_valid & alu_wbck_i_ready;
  assign longp_xfer         = longp_wbck_i_valid & longp_wbck_i_ready;
  assign xfer               = alu_xfer | longp_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld  <= 1'b0;
      stage_idx  <= '0;
      stage_data <= '0;
    end else begin
      stage_vld <= xfer | (stage_vld & rf_wbck_hold);
      if (alu_xfer) begin
        stage_idx  <= alu_wbck_i_idx;
        stage_data <= alu_wbck_i_data;
      end else if (longp_xfer) begin
        stage_idx  <= longp_wbck_i_idx;
        stage_data <= longp_wbck_i_data;
      end
    end
  end

  // Read-only targets: classical x0 and the quantum entries backed by qubits
  assign low_field  = stage_idx[QPU_RFIDX_WIDTH-1:0];
  assign is_quantum = stage_idx[QPU_RFIDX_REAL_WIDTH-1];
  assign is_ro      = is_quantum ? (low_field < QUBIT_LIM) : (low_field == '0);
  assign drain      = stage_vld & ~rf_wbck_hold;

  assign cwbck_dest_wen   = drain & ~is_quantum & ~is_ro;
  assign qcwbck_dest_wen  = drain & is_quantum & ~is_ro;
  assign wbck_drop        = drain & is_ro;
  assign wbck_busy        = stage_vld;

  assign cwbck_dest_idx   = stage_idx;
  assign cwbck_dest_data  = stage_data;
  assign qcwbck_dest_idx  = stage_idx;
  assign qcwbck_dest_data = stage_data;

endmodule

// File: tb/tb_qpu_exu_rf_wbarb.sv
// Self-checking bench for qpu_exu_rf_wbarb: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.

module tb_qpu_exu_rf_wbarb;
  import qpu_defines_pkg::*;

  localparam int unsigned IW = QPU_RFIDX_REAL_WIDTH;
  localparam int unsigned DW = QPU_XLEN;

  logic          clk, rst_n;
  logic          alu_valid, alu_ready, longp_valid, longp_ready, hold;
  logic [IW-1:0] alu_idx, longp_idx, c_idx, q_idx;
  logic [DW-1:0] alu_data, longp_data, c_data, q_data;
  logic          c_wen, q_wen, drop, busy;

  qpu_exu_rf_wbarb dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_wbck_i_valid   (alu_valid),
    .alu_wbck_i_ready   (alu_ready),
    .alu_wbck_i_idx     (alu_idx),
    .alu_wbck_i_data    (alu_data),
    .longp_wbck_i_valid (longp_valid),
    .longp_wbck_i_ready (longp_ready),
    .longp_wbck_i_idx   (longp_idx),
    .longp_wbck_i_data  (longp_data),
    .rf_wbck_hold       (hold),
    .cwbck_dest_wen     (c_wen),
    .cwbck_dest_idx     (c_idx),
    .cwbck_dest_data    (c_data),
    .qcwbck_dest_wen    (q_wen),
    .qcwbck_dest_idx    (q_idx),
    .qcwbck_dest_data   (q_data),
    .wbck_drop          (drop),
    .wbck_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wr_t;

  // Reference model: pending writes waiting for the register file, and who
  // currently has priority when both requesters compete.
  wr_t pend[$];
  bit  pri_longp;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit read_only(input logic [IW-1:0] idx);
    int unsigned low;
    low = int'(idx) % (1 << QPU_RFIDX_WIDTH);
    if (idx[IW-1]) return low < QPU_QUBIT_NUM;
    return low == 0;
  endfunction

  // One cycle: drive inputs after the falling edge, check, then advance model
  task automatic step(input bit av, input logic [IW-1:0] ai, input logic [DW-1:0] ad,
                      input bit lv, input logic [IW-1:0] li, input logic [DW-1:0] ld,
                      input bit h);
    bit full, take, drain, ro, q;
    int win;
    alu_valid = av;  alu_idx = ai;  alu_data = ad;
    longp_valid = lv; longp_idx = li; longp_data = ld;
    hold = h;
    #1;
    full  = pend.size() != 0;
    take  = !full || !h;
    drain = full && !h;
    if (av && lv)  win = pri_longp ? 2 : 1;
    else if (av)   win = 1;
    else if (lv)   win = 2;
    else           win = 0;
    ro = full && read_only(pend[0].idx);
    q  = full && pend[0].idx[IW-1];
    check("alu_ready",   32'(alu_ready),   32'(take && win == 1));
    check("longp_ready", 32'(longp_ready), 32'(take && win == 2));
    check("busy",        32'(busy),        32'(full));
    check("c_wen",       32'(c_wen),       32'(drain && !q && !ro));
    check("q_wen",       32'(q_wen),       32'(drain && q && !ro));
    check("drop",        32'(drop),        32'(drain && ro));
    if (full) begin
      check("c_idx",  32'(c_idx), 32'(pend[0].idx));
      check("q_idx",  32'(q_idx), 32'(pend[0].idx));
      check("c_data", c_data, pend[0].data);
      check("q_data", q_data, pend[0].data);
    end
    @(posedge clk);
    if (drain) void'(pend.pop_front());
    if (take && win != 0) begin
      pend.push_back(win == 1 ? '{ai, ad} : '{li, ld});
      pri_longp = (win == 1);
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit h);
    step(1'b0, '0, '0, 1'b0, '0, '0, h);
  endtask

  // Reset asserted away from the clock edge; outputs must clear immediately
  task automatic do_reset();
    rst_n = 1'b0;
    alu_valid = 1'b0; longp_valid = 1'b0; hold = 1'b0;
    #1;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_c_wen", 32'(c_wen), 32'd0);
    check("rst_q_wen", 32'(q_wen), 32'd0);
    check("rst_drop",  32'(drop),  32'd0);
    check("rst_idx",   32'(c_idx), 32'd0);
    check("rst_data",  c_data,     32'd0);
    check("rst_aready", 32'(alu_ready),   32'd0);
    check("rst_lready", 32'(longp_ready), 32'd0);
    pend.delete();
    pri_longp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [IW-1:0] qidx(input int unsigned low);
    logic [IW-1:0] v;
    v = IW'(low);
    v[IW-1] = 1'b1;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; longp_valid = 1'b0; hold = 1'b0;
    alu_idx = '0; alu_data = '0; longp_idx = '0; longp_data = '0;
    @(negedge clk);
    do_reset();

    // Single ALU write to x5
    step(1'b1, IW'(5), 32'hA5, 1'b0, '0, '0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Both requesters continuously valid from reset: alternating grants
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, IW'(i + 1), DW'(32'h100 + i), 1'b1, IW'(i + 9), DW'(32'h200 + i), 1'b0);
    idle(1'b0);

    // Full stage held for three cycles, then released
    step(1'b1, IW'(7), 32'h77, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, IW'(3), 32'h33, 1'b1, IW'(4), 32'h44, 1'b1);
    idle(1'b0);
    idle(1'b0);

    // Quantum boundary: first writable mask entry, then a read-only one
    step(1'b0, '0, '0, 1'b1, qidx(QPU_QUBIT_NUM), 32'hF0, 1'b0);
    step(1'b0, '0, '0, 1'b1, qidx(1), 32'hF1, 1'b0);
    idle(1'b0);

    // Classical x0 is dropped; priority must pass to longp afterwards
    step(1'b1, IW'(0), 32'hDEAD, 1'b0, '0, '0, 1'b0);
    step(1'b1, IW'(2), 32'h22, 1'b1, IW'(6), 32'h66, 1'b0);
    idle(1'b0);

    // Hold with empty stage: one accepted, then stalled
    step(1'b1, IW'(8), 32'h88, 1'b1, IW'(9), 32'h99, 1'b1);
    step(1'b1, IW'(8), 32'h88, 1'b1, IW'(9), 32'h99, 1'b1);
    idle(1'b0);

    // Reset with a held write in the stage
    step(1'b1, IW'(12), 32'hC0, 1'b0, '0, '0, 1'b1);
    idle(1'b1);
    do_reset();
    idle(1'b0);
    idle(1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [IW-1:0] ai, li;
      int unsigned sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       ai = '0;
        1:       ai = qidx(QPU_QUBIT_NUM - 1);
        2:       ai = qidx(QPU_QUBIT_NUM);
        default: ai = IW'($urandom);
      endcase
      sel = $urandom_range(0, 5);
      case (sel)
        0:       li = '0;
        1:       li = qidx(0);
        2:       li = qidx(QPU_QUBIT_NUM);
        default: li = IW'($urandom);
      endcase
      step(1'($urandom), ai, DW'($urandom), 1'($urandom), li, DW'($urandom),
           $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
